// File: rtl/fetch_branch_ctrl_pkg.sv
// Shared encodings for the fetch/branch control slice: state codes, opcodes,
// datapath mux selects, ALU ops and the registered control-word layout.
package fetch_branch_ctrl_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_MWAIT = 3'd2;
  localparam logic [2:0] ST_IRLD  = 3'd3;
  localparam logic [2:0] ST_DEC   = 3'd4;
  localparam logic [2:0] ST_BR    = 3'd5;
  localparam logic [2:0] ST_JMP   = 3'd6;
  localparam logic [2:0] ST_HOFF  = 3'd7;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;

  localparam logic [1:0] MEM_SEL_PC     = 2'd0;
  localparam logic [1:0] PC_SRC_ALU     = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
  localparam logic       SRC_A_PC       = 1'b0;
  localparam logic       SRC_A_REGA     = 1'b1;
  localparam logic [2:0] SRC_B_REGB     = 3'd0;
  localparam logic [2:0] SRC_B_FOUR     = 3'd1;
  localparam logic [2:0] SRC_B_IMM_SH2  = 3'd3;
  localparam logic [1:0] BR_BEQ         = 2'd0;
  localparam logic [1:0] BR_BNE         = 2'd1;
  localparam logic [1:0] BR_BLEZ        = 2'd2;
  localparam logic [1:0] BR_BGTZ        = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  typedef struct packed {
    logic [1:0] mem_sel;
    logic [1:0] pc_src_sel;
    logic       alu_src_a_sel;
    logic [2:0] alu_src_b_sel;
    logic [1:0] branch_dec_sel;
    logic [2:0] alu_op;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       aluout_write;
    logic       exec_req;
  } ctrl_t;

  // Moore control word for a given state; br_sel only matters in BR.
  function automatic ctrl_t decode_ctrl(input logic [2:0] st, input logic [1:0] br_sel);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH, ST_MWAIT: begin
        c.mem_sel       = MEM_SEL_PC;
        c.alu_src_a_sel = SRC_A_PC;
        c.alu_src_b_sel = SRC_B_FOUR;
        c.alu_op        = ALU_ADD;
      end
      ST_IRLD: begin
        c.alu_src_a_sel = SRC_A_PC;
        c.alu_src_b_sel = SRC_B_FOUR;
        c.alu_op        = ALU_ADD;
        c.pc_src_sel    = PC_SRC_ALU;
        c.pc_write      = 1'b1;
        c.ir_write      = 1'b1;
      end
      ST_DEC: begin
        c.alu_src_a_sel = SRC_A_PC;
        c.alu_src_b_sel = SRC_B_IMM_SH2;
        c.alu_op        = ALU_ADD;
        c.aluout_write  = 1'b1;
      end
      ST_BR: begin
        c.alu_src_a_sel  = SRC_A_REGA;
        c.alu_src_b_sel  = SRC_B_REGB;
        c.alu_op         = ALU_SUB;
        c.pc_src_sel     = PC_SRC_ALUOUT;
        c.pc_write_cond  = 1'b1;
        c.branch_dec_sel = br_sel;
      end
      ST_JMP: begin
        c.pc_src_sel = PC_SRC_JUMP;
        c.pc_write   = 1'b1;
      end
      ST_HOFF: c.exec_req = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_branch_ctrl_wait_counter.sv
// fetch_wait_counter: 4-bit load/decrement counter timing the memory read wait.
module fetch_wait_counter
  import fetch_branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/fetch_branch_ctrl.sv
// Fetch/decode/branch control FSM driving datapath mux selects and strobes.
// Optional misaligned-fetch trap enabled by FETCH_ALIGN_CHECK_EN.
module fetch_branch_ctrl
  import fetch_branch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned OPW     = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_zero,
  input  logic           exec_done,
  input  logic [1:0]     pc_low,
  output logic [1:0]     mem_sel,
  output logic [1:0]     pc_src_sel,
  output logic           alu_src_a_sel,
  output logic [2:0]     alu_src_b_sel,
  output logic [1:0]     branch_dec_sel,
  output logic [2:0]     alu_op,
  output logic           pc_write,
  output logic           pc_write_cond,
  output logic           ir_write,
  output logic           aluout_write,
  output logic           exec_req,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic           misalign,
`endif
  output logic [2:0]     state_o
);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  ctrl_t           r_ctrl;
  ctrl_t           w_ctrl;
  logic            w_cnt_load;
  logic            w_cnt_dec;
  logic            w_cnt_zero;
  logic            w_is_branch;
  logic [1:0]      w_br_sel;
  logic            w_misalign;
  logic            w_unused;

  fetch_wait_counter u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(MEM_LAT - 1)),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_misalign = (r_state == ST_FETCH) && (pc_low != 2'b00);
  assign misalign   = w_misalign;
  assign w_unused   = alu_zero;
`else
  assign w_misalign = 1'b0;
  assign w_unused   = ^{alu_zero, pc_low};
`endif

  assign w_is_branch = (opcode == OPW'(OP_BEQ))  || (opcode == OPW'(OP_BNE)) ||
                       (opcode == OPW'(OP_BLEZ)) || (opcode == OPW'(OP_BGTZ));

  always_comb begin
    w_br_sel = BR_BEQ;
    if (opcode == OPW'(OP_BNE))       w_br_sel = BR_BNE;
    else if (opcode == OPW'(OP_BLEZ)) w_br_sel = BR_BLEZ;
    else if (opcode == OPW'(OP_BGTZ)) w_br_sel = BR_BGTZ;
  end

  // Next state; control word is decoded from the next state so outputs stay registered.
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_RST:   w_next = ST_FETCH;
      ST_FETCH: begin
        w_cnt_load = 1'b1;
        w_next     = w_misalign ? ST_HOFF : ST_MWAIT;
      end
      ST_MWAIT: begin
        if (w_cnt_zero) w_next = ST_IRLD;
        else            w_cnt_dec = 1'b1;
      end
      ST_IRLD:  w_next = ST_DEC;
      ST_DEC: begin
        if (w_is_branch)                 w_next = ST_BR;
        else if (opcode == OPW'(OP_J))   w_next = ST_JMP;
        else                             w_next = ST_HOFF;
      end
      ST_BR, ST_JMP: w_next = ST_FETCH;
      ST_HOFF:  if (exec_done) w_next = ST_FETCH;
      default:  w_next = ST_RST;
    endcase
    w_ctrl = decode_ctrl(w_next, w_br_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_ctrl;
    end
  end

  assign mem_sel        = r_ctrl.mem_sel;
  assign pc_src_sel     = r_ctrl.pc_src_sel;
  assign alu_src_a_sel  = r_ctrl.alu_src_a_sel;
  assign alu_src_b_sel  = r_ctrl.alu_src_b_sel;
  assign branch_dec_sel = r_ctrl.branch_dec_sel;
  assign alu_op         = r_ctrl.alu_op;
  assign pc_write       = r_ctrl.pc_write;
  assign pc_write_cond  = r_ctrl.pc_write_cond;
  assign ir_write       = r_ctrl.ir_write;
  assign aluout_write   = r_ctrl.aluout_write;
  assign exec_req       = r_ctrl.exec_req;
  assign state_o        = r_state;

endmodule

// File: tb/tb_fetch_branch_ctrl.sv
// Directed, table-driven bench for fetch_branch_ctrl (MEM_LAT=2); the
// FETCH_ALIGN_CHECK_EN build adds a misaligned-fetch sequence.
module tb_fetch_branch_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       exec_done;
  logic [1:0] pc_low;
  logic [1:0] mem_sel;
  logic [1:0] pc_src_sel;
  logic       alu_src_a_sel;
  logic [2:0] alu_src_b_sel;
  logic [1:0] branch_dec_sel;
  logic [2:0] alu_op;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       aluout_write;
  logic       exec_req;
  logic [2:0] state_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic       misalign;
`endif

  int checks;
  int failures;

  fetch_branch_ctrl #(.MEM_LAT(2), .OPW(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .alu_zero       (alu_zero),
    .exec_done      (exec_done),
    .pc_low         (pc_low),
    .mem_sel        (mem_sel),
    .pc_src_sel     (pc_src_sel),
    .alu_src_a_sel  (alu_src_a_sel),
    .alu_src_b_sel  (alu_src_b_sel),
    .branch_dec_sel (branch_dec_sel),
    .alu_op         (alu_op),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .ir_write       (ir_write),
    .aluout_write   (aluout_write),
    .exec_req       (exec_req),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign       (misalign),
`endif
    .state_o        (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, mem_sel, pc_src, src_a, src_b, br_dec, alu_op, pc_w, pc_wc, ir_w, aluout_w, exec_req}
  logic [20:0] act;
  assign act = {state_o, mem_sel, pc_src_sel, alu_src_a_sel, alu_src_b_sel, branch_dec_sel,
                alu_op, pc_write, pc_write_cond, ir_write, aluout_write, exec_req};

  localparam logic [20:0] V_ZERO  = 21'd0;
  localparam logic [20:0] V_FETCH = {3'd1, 2'd0, 2'd0, 1'b0, 3'd1, 2'd0, 3'd0, 5'b00000};
  localparam logic [20:0] V_MWAIT = {3'd2, 2'd0, 2'd0, 1'b0, 3'd1, 2'd0, 3'd0, 5'b00000};
  localparam logic [20:0] V_IRLD  = {3'd3, 2'd0, 2'd0, 1'b0, 3'd1, 2'd0, 3'd0, 5'b10100};
  localparam logic [20:0] V_DEC   = {3'd4, 2'd0, 2'd0, 1'b0, 3'd3, 2'd0, 3'd0, 5'b00010};
  localparam logic [20:0] V_BEQ   = {3'd5, 2'd0, 2'd1, 1'b1, 3'd0, 2'd0, 3'd1, 5'b01000};
  localparam logic [20:0] V_BGTZ  = {3'd5, 2'd0, 2'd1, 1'b1, 3'd0, 2'd3, 3'd1, 5'b01000};
  localparam logic [20:0] V_JMP   = {3'd6, 2'd0, 2'd2, 1'b0, 3'd0, 2'd0, 3'd0, 5'b10000};
  localparam logic [20:0] V_HOFF  = {3'd7, 2'd0, 2'd0, 1'b0, 3'd0, 2'd0, 3'd0, 5'b00001};

  typedef struct {
    logic [5:0]  op;
    logic        done;
    logic [20:0] exp;
  } vec_t;

  localparam int N_VEC = 34;
  vec_t tbl [N_VEC];

  task automatic chk(input string nm, input int idx, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    opcode    = 6'h00;
    alu_zero  = 1'b1;
    exec_done = 1'b0;
    pc_low    = 2'b00;

    // beq, bgtz, jump (junk opcode while fetching), handoff with a 5-cycle wait
    tbl[0]  = '{6'h04, 1'b0, V_FETCH};
    tbl[1]  = '{6'h04, 1'b0, V_MWAIT};
    tbl[2]  = '{6'h04, 1'b0, V_MWAIT};
    tbl[3]  = '{6'h04, 1'b0, V_IRLD};
    tbl[4]  = '{6'h04, 1'b0, V_DEC};
    tbl[5]  = '{6'h04, 1'b0, V_BEQ};
    tbl[6]  = '{6'h07, 1'b0, V_FETCH};
    tbl[7]  = '{6'h07, 1'b0, V_MWAIT};
    tbl[8]  = '{6'h07, 1'b0, V_MWAIT};
    tbl[9]  = '{6'h07, 1'b0, V_IRLD};
    tbl[10] = '{6'h07, 1'b0, V_DEC};
    tbl[11] = '{6'h07, 1'b0, V_BGTZ};
    tbl[12] = '{6'h3f, 1'b0, V_FETCH};
    tbl[13] = '{6'h3f, 1'b0, V_MWAIT};
    tbl[14] = '{6'h3f, 1'b0, V_MWAIT};
    tbl[15] = '{6'h3f, 1'b0, V_IRLD};
    tbl[16] = '{6'h02, 1'b0, V_DEC};
    tbl[17] = '{6'h02, 1'b0, V_JMP};
    tbl[18] = '{6'h00, 1'b0, V_FETCH};
    tbl[19] = '{6'h00, 1'b0, V_MWAIT};
    tbl[20] = '{6'h00, 1'b1, V_MWAIT};
    tbl[21] = '{6'h00, 1'b0, V_IRLD};
    tbl[22] = '{6'h00, 1'b0, V_DEC};
    tbl[23] = '{6'h00, 1'b1, V_HOFF};
    tbl[24] = '{6'h00, 1'b0, V_HOFF};
    tbl[25] = '{6'h00, 1'b0, V_HOFF};
    tbl[26] = '{6'h00, 1'b0, V_HOFF};
    tbl[27] = '{6'h00, 1'b0, V_HOFF};
    tbl[28] = '{6'h00, 1'b1, V_FETCH};
    tbl[29] = '{6'h00, 1'b0, V_MWAIT};
    tbl[30] = '{6'h00, 1'b0, V_MWAIT};
    tbl[31] = '{6'h00, 1'b0, V_IRLD};
    tbl[32] = '{6'h00, 1'b0, V_DEC};
    tbl[33] = '{6'h00, 1'b0, V_HOFF};

    // Reset held for three edges: everything zero
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold", i, act, V_ZERO);
    end

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N_VEC; i++) begin
      opcode    = tbl[i].op;
      exec_done = tbl[i].done;
      @(posedge clk);
      #1;
      chk("vec", i, act, tbl[i].exp);
      @(negedge clk);
    end
    exec_done = 1'b0;

    // Asynchronous reset while in HOFF: exec_req drops without a clock edge
    @(posedge clk);
    #2;
    chk("pre_async", 0, act, V_HOFF);
    reset = 1'b1;
    #1;
    chk("async_reset", 0, act, V_ZERO);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("reset_hold2", i, act, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 0, act, V_FETCH);

`ifdef FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    pc_low = 2'd2;
    @(posedge clk);
    #1;
    chk("mis_fetch", 0, act, V_FETCH);
    chk("mis_pulse", 0, 21'(misalign), 21'd1);
    @(posedge clk);
    #1;
    chk("mis_hoff", 0, act, V_HOFF);
    chk("mis_drop", 0, 21'(misalign), 21'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("mis_no_irwrite", i, act, V_HOFF);
    end
    @(negedge clk);
    exec_done = 1'b1;
    pc_low    = 2'd0;
    @(posedge clk);
    #1;
    chk("mis_refetch", 0, act, V_FETCH);
    chk("mis_clear", 0, 21'(misalign), 21'd0);
    @(negedge clk);
    exec_done = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
